x_dl_ctrl: RTL and testbench
============================

X_DL_CTRL -- requirements
Module: x_dl_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 32: width of the sampled delay-line word.
REQ-002 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  one-cycle request to begin a measurement.
REQ-005 SHALL have port i_abort  input  1  cancel the current measurement.
REQ-006 SHALL have port i_cfg_log2n  input  3  log2 of the sample count N (N = 1..128).
REQ-007 SHALL have port i_dl_data  input  N_TAPS  registered delay-line capture word.
REQ-008 SHALL have port o_dl_en  output  1  enable to the delay-line launch/capture logic.
REQ-009 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port o_valid  output  1  result available.
REQ-011 SHALL have port i_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port o_sum  output  13  sum of N tap positions.
REQ-013 SHALL have port o_mean  output  6  o_sum >> i_cfg_log2n, truncated.
REQ-014 SHALL have ports o_min and o_max  output  6 each  extreme tap positions (see REQ-030).

Function
REQ-015 SHALL decode each i_dl_data word to a position P in 0..32: P = lowest k in 1..31 with d[k] == d[k-1], and P = 32 if no such k.
REQ-016 SHALL implement the FSM states IDLE, FLUSH, ACC and DONE.
REQ-017 IDLE: o_dl_en = 0; i_start = 1 -> FLUSH; i_cfg_log2n is latched on that edge.
REQ-018 FLUSH: o_dl_en = 1 for exactly 2 cycles to drain the 2-stage capture pipe; no samples are taken; then -> ACC.
REQ-019 ACC: o_dl_en = 1; one P accumulated per cycle; after exactly N samples -> DONE.
REQ-020 DONE: o_dl_en = 0, o_valid = 1; outputs held stable until i_valid&&i_ready handshake, then -> IDLE.
REQ-021 The result registers (sum/mean/min/max) SHALL update only on the DONE entry edge and SHALL hold their values through IDLE.
REQ-022 The sum SHALL saturate-free fit 13 bits (max 128*32 = 4096); no wrap SHALL occur.
REQ-023 i_start while o_busy = 1 SHALL be ignored, including in DONE.
REQ-024 i_abort in FLUSH or ACC SHALL go to IDLE next cycle, discard partial results, and not assert o_valid.
REQ-025 i_abort in DONE or IDLE SHALL have no effect.
REQ-026 i_abort and i_start asserted together in IDLE SHALL start (abort ignored).
REQ-027 Changes to i_cfg_log2n during a measurement SHALL not affect it.
REQ-028 The latency from i_start to o_valid SHALL be exactly 3 + N cycles.

Reset
REQ-029 On i_rst_n = 0, asynchronously: state = IDLE; o_dl_en = 0, o_busy = 0, o_valid = 0; o_sum = 0, o_mean = 0, o_min = 0, o_max = 0; counters = 0. Reset mid-operation SHALL lose the measurement with no o_valid pulse.

Configuration
REQ-030 Macro X_DL_CTRL_MINMAX_EN: when defined, o_min/o_max SHALL track the min/max of P over the N samples (running min initialised to 32, running max initialised to 0 at FLUSH entry); when undefined, no min/max logic SHALL exist and o_min/o_max SHALL be tied to 0.

Verification
REQ-031 With log2n = 0, constant data 32'h5555_5555 (P = 32), i_start -> o_valid exactly 4 cycles later; sum = 32, mean = 32.
REQ-032 With log2n = 2 and data giving P = 3, 5, 7, 9 -> sum = 24, mean = 6; with MINMAX_EN, min = 3 and max = 9.
REQ-033 With log2n = 7 and P = 32 every cycle -> sum = 4096, mean = 32, o_valid after 131 cycles.
REQ-034 i_abort in the 3rd ACC cycle -> IDLE next cycle, o_valid never asserted, previous result unchanged.
REQ-035 Hold i_ready = 0 for 10 cycles in DONE and pulse i_start meanwhile -> outputs stable, start ignored; i_ready = 1 -> IDLE.
REQ-036 Deassert i_rst_n in ACC -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/x_dl_ctrl.sv
// Delay-line measurement controller: flushes the capture pipe, then decodes N samples into tap positions and accumulates them.
// Latency: o_valid rises 3+N cycles after the cycle in which i_start is high; results are held until the i_ready handshake.
// Backpressure: DONE holds o_valid and all results stable while i_ready is low. i_start is ignored while busy.
// Optional feature: define X_DL_CTRL_MINMAX_EN to track the min/max tap position; otherwise o_min/o_max are tied to 0.
module x_dl_ctrl #(
  parameter int N_TAPS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [2:0]        i_cfg_log2n,
  input  logic [N_TAPS-1:0] i_dl_data,
  input  logic              i_ready,
  output logic              o_dl_en,
  output logic              o_busy,
  output logic              o_valid,
  output logic [12:0]       o_sum,
  output logic [5:0]        o_mean,
  output logic [5:0]        o_min,
  output logic [5:0]        o_max
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_ACC   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  log2n_q;
  logic [12:0] acc_q;

  logic [5:0]  p_dec;
  logic [12:0] acc_sum_d;
  logic [7:0]  n_last;

  // The tap position is the first index where two neighbouring capture bits agree;
  // a fully alternating word means the edge ran off the end of the line.
  always_comb begin
    logic found;
    found = 1'b0;
    p_dec = 6'(N_TAPS);
    for (int k = 1; k < N_TAPS; k++) begin
      if (!found && (i_dl_data[k] == i_dl_data[k-1])) begin
        p_dec = 6'(k);
        found = 1'b1;
      end
    end
  end

  // Running sum including the current sample; 128 * 32 = 4096 fits 13 bits without wrap.
  assign acc_sum_d = acc_q + 13'(p_dec);
  // Index of the final sample for the latched sample count.
  assign n_last    = (8'd1 << log2n_q) - 8'd1;

`ifdef X_DL_CTRL_MINMAX_EN
  logic [5:0] min_q;
  logic [5:0] max_q;
  logic [5:0] min_d;
  logic [5:0] max_d;

  // Running extremes including the current sample.
  always_comb begin
    min_d = (p_dec < min_q) ? p_dec : min_q;
    max_d = (p_dec > max_q) ? p_dec : max_q;
  end
`else
  assign o_min = '0;
  assign o_max = '0;
`endif

  // Control FSM with registered outputs; result registers load only on the ACC->DONE edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      log2n_q <= '0;
      acc_q   <= '0;
      o_dl_en <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_mean  <= '0;
`ifdef X_DL_CTRL_MINMAX_EN
      min_q   <= '0;
      max_q   <= '0;
      o_min   <= '0;
      o_max   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // Abort has no meaning here, so a simultaneous start still wins.
          if (i_start) begin
            state_q <= S_FLUSH;
            log2n_q <= i_cfg_log2n;
            cnt_q   <= '0;
            acc_q   <= '0;
            o_dl_en <= 1'b1;
            o_busy  <= 1'b1;
`ifdef X_DL_CTRL_MINMAX_EN
            min_q   <= 6'd32;
            max_q   <= 6'd0;
`endif
          end
        end
        S_FLUSH: begin
          if (i_abort) begin
            state_q <= S_IDLE;
            o_dl_en <= 1'b0;
            o_busy  <= 1'b0;
          end else if (cnt_q == 8'd1) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        S_ACC: begin
          if (i_abort) begin
            state_q <= S_IDLE;
            o_dl_en <= 1'b0;
            o_busy  <= 1'b0;
          end else begin
            acc_q <= acc_sum_d;
`ifdef X_DL_CTRL_MINMAX_EN
            min_q <= min_d;
            max_q <= max_d;
`endif
            if (cnt_q == n_last) begin
              state_q <= S_DONE;
              o_dl_en <= 1'b0;
              o_valid <= 1'b1;
              o_sum   <= acc_sum_d;
              o_mean  <= 6'(acc_sum_d >> log2n_q);
`ifdef X_DL_CTRL_MINMAX_EN
              o_min   <= min_d;
              o_max   <= max_d;
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_DONE: begin
          // o_valid is always high here, so the handshake reduces to i_ready.
          if (i_ready) begin
            state_q <= S_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          o_dl_en <= 1'b0;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_dl_ctrl.sv
// Directed bench for x_dl_ctrl: latency, sum/mean/min/max, abort, DONE hold, and async reset.
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
// Min/max expectations follow whether X_DL_CTRL_MINMAX_EN is defined for the build.
module tb_x_dl_ctrl;

`ifdef X_DL_CTRL_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  cfg;
  logic [31:0] dl;
  logic        ready;
  logic        dl_en;
  logic        busy;
  logic        valid;
  logic [12:0] sum;
  logic [5:0]  mean;
  logic [5:0]  mn;
  logic [5:0]  mx;

  int checks = 0;
  int fails  = 0;
  int pat[128];
  bit pre_valid;

  x_dl_ctrl #(.N_TAPS(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_cfg_log2n(cfg), .i_dl_data(dl), .i_ready(ready),
    .o_dl_en(dl_en), .o_busy(busy), .o_valid(valid),
    .o_sum(sum), .o_mean(mean), .o_min(mn), .o_max(mx)
  );

  always #5 clk = ~clk;

  // Capture word whose decoded position is p: alternating bits, inverted from bit p upward.
  function automatic logic [31:0] word_for(input int p);
    logic [31:0] alt;
    logic [31:0] ones;
    alt  = 32'h5555_5555;
    ones = 32'hFFFF_FFFF;
    if (p >= 32) return alt;
    return alt ^ (ones << p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas(input int l2n, input bit with_abort);
    cfg   = 3'(l2n);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Two flush cycles of junk data (P=1), then n samples from pat[]; flags any early o_valid.
  task automatic feed(input int n);
    pre_valid = 1'b0;
    dl = 32'h0;
    repeat (2) begin
      if (valid) pre_valid = 1'b1;
      tick();
    end
    for (int j = 0; j < n; j++) begin
      if (valid) pre_valid = 1'b1;
      dl = word_for(pat[j]);
      tick();
    end
    dl = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg = 3'd0; dl = 32'h0; ready = 1'b0;
    tick(); tick();
    checks++; if (dl_en !== 1'b0) begin fails++; $display("FAIL reset_dl_en: got %0b expected 0", dl_en); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (sum !== 13'd0) begin fails++; $display("FAIL reset_sum: got %0d expected 0", sum); end
    checks++; if (mean !== 6'd0) begin fails++; $display("FAIL reset_mean: got %0d expected 0", mean); end
    checks++; if (mn !== 6'd0 || mx !== 6'd0) begin fails++; $display("FAIL reset_minmax: got %0d/%0d expected 0/0", mn, mx); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    pat[0] = 32;
    start_meas(0, 1'b0);
    checks++; if (busy !== 1'b1 || dl_en !== 1'b1) begin fails++; $display("FAIL single_flush_flags: got busy=%0b dl_en=%0b expected 1/1", busy, dl_en); end
    feed(1);
    checks++; if (pre_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %0b expected 0", pre_valid); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL single_latency4: got valid=%0b expected 1", valid); end
    checks++; if (sum !== 13'd32) begin fails++; $display("FAIL single_sum: got %0d expected 32", sum); end
    checks++; if (mean !== 6'd32) begin fails++; $display("FAIL single_mean: got %0d expected 32", mean); end
    checks++; if (dl_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_done_flags: got dl_en=%0b busy=%0b expected 0/1", dl_en, busy); end
    checks++; if (mn !== (MM ? 6'd32 : 6'd0) || mx !== (MM ? 6'd32 : 6'd0)) begin fails++; $display("FAIL single_minmax: got %0d/%0d expected %0d/%0d", mn, mx, MM ? 32 : 0, MM ? 32 : 0); end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_handshake: got valid=%0b busy=%0b expected 0/0", valid, busy); end
    tick();
    checks++; if (sum !== 13'd32) begin fails++; $display("FAIL single_hold_idle: got %0d expected 32", sum); end
  endtask

  task automatic test_mean_minmax();
    pat[0] = 3; pat[1] = 5; pat[2] = 7; pat[3] = 9;
    start_meas(2, 1'b0);
    feed(4);
    checks++; if (pre_valid !== 1'b0 || valid !== 1'b1) begin fails++; $display("FAIL mm4_latency: got early=%0b valid=%0b expected 0/1", pre_valid, valid); end
    checks++; if (sum !== 13'd24) begin fails++; $display("FAIL mm4_sum: got %0d expected 24", sum); end
    checks++; if (mean !== 6'd6) begin fails++; $display("FAIL mm4_mean: got %0d expected 6", mean); end
    checks++; if (mn !== (MM ? 6'd3 : 6'd0) || mx !== (MM ? 6'd9 : 6'd0)) begin fails++; $display("FAIL mm4_minmax: got %0d/%0d expected %0d/%0d", mn, mx, MM ? 3 : 0, MM ? 9 : 0); end
    ready = 1'b1; tick(); ready = 1'b0;
    pat[0] = 1; pat[1] = 2; pat[2] = 4; pat[3] = 8; pat[4] = 16; pat[5] = 31; pat[6] = 32; pat[7] = 10;
    start_meas(3, 1'b0);
    feed(8);
    checks++; if (pre_valid !== 1'b0 || valid !== 1'b1) begin fails++; $display("FAIL mm8_latency: got early=%0b valid=%0b expected 0/1", pre_valid, valid); end
    checks++; if (sum !== 13'd104) begin fails++; $display("FAIL mm8_sum: got %0d expected 104", sum); end
    checks++; if (mean !== 6'd13) begin fails++; $display("FAIL mm8_mean: got %0d expected 13", mean); end
    checks++; if (mn !== (MM ? 6'd1 : 6'd0) || mx !== (MM ? 6'd32 : 6'd0)) begin fails++; $display("FAIL mm8_minmax: got %0d/%0d expected %0d/%0d", mn, mx, MM ? 1 : 0, MM ? 32 : 0); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_full_scale();
    for (int j = 0; j < 128; j++) pat[j] = 32;
    start_meas(7, 1'b0);
    feed(128);
    checks++; if (pre_valid !== 1'b0 || valid !== 1'b1) begin fails++; $display("FAIL full_latency131: got early=%0b valid=%0b expected 0/1", pre_valid, valid); end
    checks++; if (sum !== 13'd4096) begin fails++; $display("FAIL full_sum: got %0d expected 4096", sum); end
    checks++; if (mean !== 6'd32) begin fails++; $display("FAIL full_mean: got %0d expected 32", mean); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    start_meas(3, 1'b0);
    dl = 32'h0;
    tick(); tick();
    checks++; if (dl_en !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL abort_acc_flags: got dl_en=%0b busy=%0b expected 1/1", dl_en, busy); end
    dl = word_for(5);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || dl_en !== 1'b0) begin fails++; $display("FAIL abort_to_idle: got busy=%0b dl_en=%0b expected 0/0", busy, dl_en); end
    seen = 1'b0;
    repeat (12) begin tick(); if (valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_valid: got %0b expected 0", seen); end
    checks++; if (sum !== 13'd4096 || mean !== 6'd32) begin fails++; $display("FAIL abort_prev_kept: got %0d/%0d expected 4096/32", sum, mean); end
    checks++; if (mn !== (MM ? 6'd32 : 6'd0) || mx !== (MM ? 6'd32 : 6'd0)) begin fails++; $display("FAIL abort_minmax_kept: got %0d/%0d expected %0d/%0d", mn, mx, MM ? 32 : 0, MM ? 32 : 0); end
    // Abort during flush also returns to idle.
    start_meas(0, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_flush: got busy=%0b expected 0", busy); end
    // Abort in idle does nothing.
    abort = 1'b1; tick(); abort = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); if (valid || busy) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_idle_quiet: got %0b expected 0", seen); end
  endtask

  task automatic test_done_hold();
    bit seen;
    pat[0] = 5; pat[1] = 7;
    start_meas(1, 1'b0);
    feed(2);
    checks++; if (valid !== 1'b1 || sum !== 13'd12 || mean !== 6'd6) begin fails++; $display("FAIL hold_result: got valid=%0b sum=%0d mean=%0d expected 1/12/6", valid, sum, mean); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 6) abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++; if (valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL hold_valid_c%0d: got valid=%0b busy=%0b expected 1/1", i, valid, busy); end
      checks++; if (sum !== 13'd12 || mean !== 6'd6) begin fails++; $display("FAIL hold_stable_c%0d: got %0d/%0d expected 12/6", i, sum, mean); end
    end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hold_release: got valid=%0b busy=%0b expected 0/0", valid, busy); end
    seen = 1'b0;
    repeat (8) begin tick(); if (busy || valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL hold_start_ignored: got %0b expected 0", seen); end
  endtask

  task automatic test_start_abort_cfg();
    pat[0] = 32; pat[1] = 32;
    start_meas(1, 1'b1);
    cfg = 3'd7;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL start_abort_starts: got busy=%0b expected 1", busy); end
    feed(2);
    checks++; if (pre_valid !== 1'b0 || valid !== 1'b1) begin fails++; $display("FAIL cfg_latched_latency: got early=%0b valid=%0b expected 0/1", pre_valid, valid); end
    checks++; if (sum !== 13'd64 || mean !== 6'd32) begin fails++; $display("FAIL cfg_latched_result: got %0d/%0d expected 64/32", sum, mean); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_meas(3, 1'b0);
    dl = word_for(4);
    tick(); tick(); tick(); tick();
    checks++; if (busy !== 1'b1 || dl_en !== 1'b1) begin fails++; $display("FAIL rstmid_in_acc: got busy=%0b dl_en=%0b expected 1/1", busy, dl_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dl_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got %0b%0b%0b expected 000", dl_en, busy, valid); end
    checks++; if (sum !== 13'd0 || mean !== 6'd0 || mn !== 6'd0 || mx !== 6'd0) begin fails++; $display("FAIL rstmid_results: got %0d/%0d/%0d/%0d expected 0/0/0/0", sum, mean, mn, mx); end
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin tick(); if (valid || busy) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_valid: got %0b expected 0", seen); end
    pat[0] = 7;
    start_meas(0, 1'b0);
    feed(1);
    checks++; if (valid !== 1'b1 || sum !== 13'd7 || mean !== 6'd7) begin fails++; $display("FAIL rstmid_recover: got valid=%0b sum=%0d mean=%0d expected 1/7/7", valid, sum, mean); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_mean_minmax();
    test_full_scale();
    test_abort();
    test_done_hold();
    test_start_abort_cfg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
